per_bus_arbiter: RTL and testbench

- Shares the single peripheral bus (UART and future peripherals) between two requesters: M0 = BIP CPU, M1 = UART debug/loader path.
- Sequences each access as a fixed-length chip-select window.
- Captures read data and returns a one-cycle acknowledge to the winning master.
- Sits between the requesters and the peripheral address/cs/w_r/data lines.

---
 rtl/per_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_per_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/per_bus_arbiter.sv
// per_bus_arbiter: shares the peripheral bus between M0 (CPU) and M1 (UART loader).
// Each access is a fixed ACCESS_CYCLES chip-select window followed by a one-cycle ack.
// Optional build macro: PER_BUS_ARB_RR_EN -- round-robin on ties (default: M0 fixed priority).
module per_bus_arbiter #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic                  i_w_r0,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    output logic                  o_gnt0,
    output logic                  o_ack0,
    input  logic                  i_req1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic                  i_w_r1,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_gnt1,
    output logic                  o_ack1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_cs,
    output logic                  o_w_r,
    output logic [DATA_WIDTH-1:0] o_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata
);

    localparam int unsigned CNT_W = 4;

    // Reject window lengths the 4-bit counter cannot represent.
    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
        $error("per_bus_arbiter: ACCESS_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner1;   // 1 when M1 owns the current transaction
    logic             win1_c;   // M1 wins arbitration this cycle

`ifdef PER_BUS_ARB_RR_EN
    logic last1;                // last-grant pointer, 1 = M1 was served last

    // Tie goes to the master that was not served last.
    assign win1_c = i_req1 & (~i_req0 | ~last1);
`else
    // Tie always goes to the CPU.
    assign win1_c = i_req1 & ~i_req0;
`endif

    // Arbitration FSM with registered bus, grant and ack outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            owner1  <= 1'b0;
            o_gnt0  <= 1'b0;
            o_gnt1  <= 1'b0;
            o_ack0  <= 1'b0;
            o_ack1  <= 1'b0;
            o_cs    <= 1'b0;
            o_w_r   <= 1'b0;
            o_addr  <= '0;
            o_wdata <= '0;
            o_rdata <= '0;
`ifdef PER_BUS_ARB_RR_EN
            last1   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req0 || i_req1) begin
                        state   <= ACCESS;
                        cnt     <= '0;
                        owner1  <= win1_c;
                        o_gnt0  <= ~win1_c;
                        o_gnt1  <= win1_c;
                        o_cs    <= 1'b1;
                        o_addr  <= win1_c ? i_addr1  : i_addr0;
                        o_w_r   <= win1_c ? i_w_r1   : i_w_r0;
                        o_wdata <= win1_c ? i_wdata1 : i_wdata0;
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_W'(ACCESS_CYCLES - 1)) begin
                        state  <= DONE;
                        o_cs   <= 1'b0;
                        o_ack0 <= ~owner1;
                        o_ack1 <= owner1;
                        if (!o_w_r) begin
                            o_rdata <= i_rdata;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_ack0 <= 1'b0;
                    o_ack1 <= 1'b0;
                    o_gnt0 <= 1'b0;
                    o_gnt1 <= 1'b0;
`ifdef PER_BUS_ARB_RR_EN
                    last1  <= owner1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_per_bus_arbiter.sv
// Scoreboard bench for per_bus_arbiter (ACCESS_CYCLES=3); honours PER_BUS_ARB_RR_EN.
module tb_per_bus_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;
    localparam int unsigned AC = 3;

    typedef struct {
        logic          m1;
        logic          w_r;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_req0 = 1'b0, i_req1 = 1'b0;
    logic [AW-1:0] i_addr0 = '0, i_addr1 = '0;
    logic          i_w_r0 = 1'b0, i_w_r1 = 1'b0;
    logic [DW-1:0] i_wdata0 = '0, i_wdata1 = '0;
    logic [DW-1:0] i_rdata = '0;
    logic          o_gnt0, o_gnt1, o_ack0, o_ack1, o_cs, o_w_r;
    logic [DW-1:0] o_rdata, o_wdata;
    logic [AW-1:0] o_addr;

    int            errors = 0;
    int            checks = 0;
    exp_t          q[$];
    logic [DW-1:0] last_rd = '0;
    int            cs_cnt = 0;
    exp_t          mon_e;

    per_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(AC)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_addr0(i_addr0), .i_w_r0(i_w_r0), .i_wdata0(i_wdata0),
        .o_gnt0(o_gnt0), .o_ack0(o_ack0),
        .i_req1(i_req1), .i_addr1(i_addr1), .i_w_r1(i_w_r1), .i_wdata1(i_wdata1),
        .o_gnt1(o_gnt1), .o_ack1(o_ack1),
        .o_rdata(o_rdata), .o_addr(o_addr), .o_cs(o_cs), .o_w_r(o_w_r),
        .o_wdata(o_wdata), .i_rdata(i_rdata)
    );

    always #5 i_clk = ~i_clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected response of a transaction, with read-data hold modelled here.
    task automatic push_exp(input logic m1, input logic w_r, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rd);
        exp_t e;
        e.m1 = m1; e.w_r = w_r; e.addr = addr; e.wdata = wdata;
        if (!w_r) last_rd = rd;
        e.rdata = last_rd;
        q.push_back(e);
    endtask

    task automatic set_m(input logic m1, input logic req, input logic w_r,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (m1) begin
            i_req1 = req; i_w_r1 = w_r; i_addr1 = addr; i_wdata1 = wdata;
        end else begin
            i_req0 = req; i_w_r0 = w_r; i_addr0 = addr; i_wdata0 = wdata;
        end
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    // Wait for k acks, bounded; requests are dropped by the caller in the ack cycle.
    task automatic wait_acks(input int k, input int limit, input string name);
        int seen = 0;
        int n = 0;
        while (seen < k && n < limit) begin
            step();
            n++;
            if (o_ack0 || o_ack1) seen++;
        end
        chk(name, 32'(seen), 32'(k));
    endtask

    // One isolated transaction: request in an IDLE cycle, check req-to-ack latency.
    task automatic single(input logic m1, input logic w_r, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rd, input string name);
        int n = 0;
        logic got = 1'b0;
        step();
        i_rdata = rd;
        set_m(m1, 1'b1, w_r, addr, wdata);
        push_exp(m1, w_r, addr, wdata, rd);
        while (!got && n < 20) begin
            step();
            n++;
            got = m1 ? o_ack1 : o_ack0;
        end
        chk({name, "_latency"}, 32'(n), 32'(AC + 1));
        set_m(m1, 1'b0, 1'b0, addr, wdata);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk(name, 32'(q.size()), 32'(0));
    endtask

    // Monitor: bus contents during chip-select, ack ordering, cs length and read data.
    always @(negedge i_clk) begin
        if (i_rst) begin
            cs_cnt = 0;
        end else begin
            chk("gnt_exclusive", 32'(o_gnt0 & o_gnt1), 32'(0));
            if (o_cs) begin
                cs_cnt++;
                if (q.size() == 0) begin
                    chk("cs_unexpected", 32'(o_cs), 32'(0));
                end else begin
                    mon_e = q[0];
                    chk("cs_addr", 32'(o_addr), 32'(mon_e.addr));
                    chk("cs_w_r", 32'(o_w_r), 32'(mon_e.w_r));
                    chk("cs_wdata", 32'(o_wdata), 32'(mon_e.wdata));
                    chk("cs_gnt", 32'({o_gnt1, o_gnt0}), mon_e.m1 ? 32'(2) : 32'(1));
                end
            end
            if (o_ack0 || o_ack1) begin
                if (q.size() == 0) begin
                    chk("ack_unexpected", 32'({o_ack1, o_ack0}), 32'(0));
                end else begin
                    mon_e = q.pop_front();
                    chk("ack_master", 32'({o_ack1, o_ack0}), mon_e.m1 ? 32'(2) : 32'(1));
                    chk("ack_gnt", 32'({o_gnt1, o_gnt0}), mon_e.m1 ? 32'(2) : 32'(1));
                    chk("ack_cs_low", 32'(o_cs), 32'(0));
                    chk("cs_len", 32'(cs_cnt), 32'(AC));
                    chk("ack_rdata", 32'(o_rdata), 32'(mon_e.rdata));
                end
                cs_cnt = 0;
            end
        end
    end

    initial begin
        #3;
        chk("rst_cs", 32'(o_cs), 32'(0));
        chk("rst_gnt", 32'({o_gnt1, o_gnt0}), 32'(0));
        chk("rst_ack", 32'({o_ack1, o_ack0}), 32'(0));
        chk("rst_rdata", 32'(o_rdata), 32'(0));
        chk("rst_bus", 32'({o_w_r, o_addr, o_wdata}), 32'(0));
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Plain transactions, read hold across a write.
        single(1'b0, 1'b1, 10'h005, 16'hA55A, 16'hDEAD, "m0_write");
        single(1'b1, 1'b0, 10'h3FF, 16'h0000, 16'h1234, "m1_read");
        single(1'b0, 1'b1, 10'h0C3, 16'h5555, 16'hFFFF, "m0_write_hold");
        single(1'b0, 1'b0, 10'h111, 16'h0000, 16'hBEEF, "m0_read");
        wait_drain("drain_basic");

        // Request dropped and master inputs changed mid-access.
        step();
        i_rdata = 16'h4242;
        set_m(1'b0, 1'b1, 1'b1, 10'h100, 16'h0102);
        push_exp(1'b0, 1'b1, 10'h100, 16'h0102, 16'h4242);
        step();
        set_m(1'b0, 1'b0, 1'b0, 10'h2AA, 16'hFFFF);
        wait_acks(1, 10, "drop_ack");
        repeat (6) step();
        wait_drain("drain_drop");

        // Continuous tie over three transactions.
        step();
        i_rdata = 16'h0F0F;
        set_m(1'b0, 1'b1, 1'b0, 10'h011, 16'h1111);
        set_m(1'b1, 1'b1, 1'b0, 10'h022, 16'h2222);
`ifdef PER_BUS_ARB_RR_EN
        push_exp(1'b0, 1'b0, 10'h011, 16'h1111, 16'h0F0F);
        push_exp(1'b1, 1'b0, 10'h022, 16'h2222, 16'h0F0F);
        push_exp(1'b0, 1'b0, 10'h011, 16'h1111, 16'h0F0F);
`else
        push_exp(1'b0, 1'b0, 10'h011, 16'h1111, 16'h0F0F);
        push_exp(1'b0, 1'b0, 10'h011, 16'h1111, 16'h0F0F);
        push_exp(1'b0, 1'b0, 10'h011, 16'h1111, 16'h0F0F);
`endif
        wait_acks(3, 3 * (AC + 2) + 5, "tie_acks");
        set_m(1'b0, 1'b0, 1'b0, 10'h011, 16'h1111);
        set_m(1'b1, 1'b0, 1'b0, 10'h022, 16'h2222);
        wait_drain("drain_tie");

        // Asynchronous reset in the middle of an M1 access window.
        step();
        i_rdata = 16'h7777;
        set_m(1'b1, 1'b1, 1'b0, 10'h0AB, 16'h0000);
        push_exp(1'b1, 1'b0, 10'h0AB, 16'h0000, 16'h7777);
        step();
        step();
        chk("pre_rst_cs", 32'(o_cs), 32'(1));
        #2;
        i_rst = 1'b1;
        q.delete();
        last_rd = '0;
        #1;
        chk("mid_rst_cs", 32'(o_cs), 32'(0));
        chk("mid_rst_gnt", 32'({o_gnt1, o_gnt0}), 32'(0));
        chk("mid_rst_ack", 32'({o_ack1, o_ack0}), 32'(0));
        chk("mid_rst_rdata", 32'(o_rdata), 32'(0));
        set_m(1'b1, 1'b0, 1'b0, 10'h0AB, 16'h0000);
        step();
        i_rst = 1'b0;
        begin
            int acks = 0;
            repeat (8) begin
                step();
                if (o_ack0 || o_ack1) acks++;
            end
            chk("no_ack_after_rst", 32'(acks), 32'(0));
        end

        // First tie after reset goes to M0 in either build.
        step();
        i_rdata = 16'h5A5A;
        set_m(1'b0, 1'b1, 1'b0, 10'h033, 16'h3333);
        set_m(1'b1, 1'b1, 1'b0, 10'h044, 16'h4444);
        push_exp(1'b0, 1'b0, 10'h033, 16'h3333, 16'h5A5A);
        wait_acks(1, 10, "post_rst_tie");
        set_m(1'b0, 1'b0, 1'b0, 10'h033, 16'h3333);
        set_m(1'b1, 1'b0, 1'b0, 10'h044, 16'h4444);
        repeat (4) step();
        wait_drain("drain_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
